hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the performance counters.
REQ-002 Port Clock, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port Reset, input, 1: synchronous, active-high reset.
REQ-004 Port iValidID, input, 1: the ID stage holds a real instruction.
REQ-005 Port iRdA / iRdB, input, 1 each: the ID instruction reads register A / register B.
REQ-006 Port iSelAID / iSelBID, input, 2 each: writeback selects of the ID instruction; nonzero means it writes A / B.
REQ-007 Port iJmpID / iBranchID, input, 1 each: decoder jump enable / taken-branch enable for the ID instruction.
REQ-008 Port iHaltReq, input, 1: external request to drain and halt the pipeline.
REQ-009 Port oHoldPC / oHoldIFID, output, 1 each: hold the PC / hold the IF-ID register.
REQ-010 Port oBubbleEX, output, 1: force the ID-EX registers to NOP (SelA=SelB=0, WrEnable=0).
REQ-011 Port oRedirect, output, 1: permit the PC mux to take the jump/branch target; 0 forces PC_Next.
REQ-012 Port oSquashID, output, 1: treat the ID instruction as a bubble.
REQ-013 Port oHalted, output, 1: pipeline is empty and frozen.
REQ-014 Port oStallCnt / oFlushCnt, output, CNT_W each: stall-cycle and flush-event counters.

Function
REQ-015 A scoreboard SHALL keep pending-write bits pA[2:0] and pB[2:0] for the EX, ME and WB stages; each cycle pX[2:1] <= pX[1:0].
REQ-016 pA[0] SHALL load (iSelAID!=0)&iValidID&~oBubbleEX&~oSquashID, and pB[0] likewise; a bubble SHALL shift in 0.
REQ-017 hazard = iValidID & ~oSquashID & ((iRdA & |pA) | (iRdB & |pB)).
REQ-018 States: RUN, STALL, FLUSH, DRAIN, HALT; encoding is free.
REQ-019 RUN: if hazard, go to STALL; else if (iJmpID|iBranchID) & iValidID, assert oRedirect and go to FLUSH; else stay in RUN.
REQ-020 STALL: oHoldPC=oHoldIFID=oBubbleEX=1 and oRedirect=0; return to RUN in the first cycle hazard=0, with the RUN outputs evaluated in that same cycle. Maximum stall is 3 cycles.
REQ-021 FLUSH: one cycle; oSquashID=1 and oRedirect=0; go to RUN.
REQ-022 Hazard and jump in the same cycle: the stall SHALL win and the redirect SHALL be deferred until the stall clears. A jump is never lost.
REQ-023 When iHaltReq=1 in RUN or FLUSH, the block SHALL go to DRAIN, finishing the FLUSH cycle first. In STALL, it goes to DRAIN when the stall clears.
REQ-024 DRAIN: oHoldPC=oHoldIFID=oBubbleEX=1 and oRedirect=0; go to HALT when pA==0 and pB==0.
REQ-025 HALT: oHalted=1 and holds as in DRAIN; on iHaltReq=0 go to RUN with oHalted=0 in that cycle.
REQ-026 All outputs except the counters SHALL be combinational from state and inputs. Internal state SHALL update one cycle after the qualifying condition.
REQ-027 oStallCnt SHALL increment in each STALL cycle. oFlushCnt SHALL increment on each oRedirect=1 cycle. Both saturate at all-ones.
REQ-028 Outputs SHALL never assert oRedirect together with oHoldPC.

Reset
REQ-029 While Reset=1, state=RUN, pA=pB=0 and both counters=0.
REQ-030 While Reset=1, oHoldPC, oHoldIFID, oBubbleEX, oRedirect, oSquashID and oHalted SHALL all be 0.
REQ-031 Reset asserted mid-STALL, mid-DRAIN or in HALT SHALL return the block to RUN on the next edge, discarding pending redirects and halts.

Verification
REQ-032 Producer writes A (SelA=2) and the next instruction reads A: 3 stall cycles, oBubbleEX=1 for 3 cycles, then RUN; oStallCnt=3.
REQ-033 Producer, one independent instruction, then a consumer of A: 2 stall cycles, oStallCnt=2.
REQ-034 iJmpID=1 with no hazard: oRedirect=1 for 1 cycle, oSquashID=1 the next cycle; oFlushCnt=1.
REQ-035 Jump that also reads B while pB[1]=1: oRedirect=0 for 2 cycles, then oRedirect=1, then oSquashID=1.
REQ-036 iHaltReq with pA=3'b011: DRAIN for 3 cycles, then oHalted=1; drop iHaltReq: oHalted=0 the same cycle.
REQ-037 Reset pulse during STALL: next cycle all outputs 0, counters 0, hazard re-evaluated against a clear scoreboard.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: RAW stall detection against an EX/ME/WB write scoreboard,
// jump/branch redirect and flush sequencing, drain-and-halt control, stall/flush counters.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iValidID,
  input  logic             iRdA,
  input  logic             iRdB,
  input  logic [1:0]       iSelAID,
  input  logic [1:0]       iSelBID,
  input  logic             iJmpID,
  input  logic             iBranchID,
  input  logic             iHaltReq,
  output logic             oHoldPC,
  output logic             oHoldIFID,
  output logic             oBubbleEX,
  output logic             oRedirect,
  output logic             oSquashID,
  output logic             oHalted,
  output logic [CNT_W-1:0] oStallCnt,
  output logic [CNT_W-1:0] oFlushCnt
);

  localparam logic [2:0] RUN   = 3'd0;
  localparam logic [2:0] STALL = 3'd1;
  localparam logic [2:0] FLUSH = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] HALT  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [2:0]       pA_q, pA_d, pB_q, pB_d;
  logic             jmpPend_q, jmpPend_d, haltPend_q, haltPend_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d, flushCnt_q, flushCnt_d;

  logic runLike, hazard, stallNow, jumpReq, haltWant;
  logic redirect, squash, halted, holdAll;

  // STALL and a HALT being released both present RUN behaviour whenever no hazard is live.
  always_comb begin
    squash   = (state_q == FLUSH);
    runLike  = (state_q == RUN) | (state_q == STALL) | ((state_q == HALT) & ~iHaltReq);
    hazard   = iValidID & ~squash & ((iRdA & (|pA_q)) | (iRdB & (|pB_q)));
    stallNow = runLike & hazard;
    jumpReq  = ((iJmpID | iBranchID) & iValidID) | jmpPend_q;
    haltWant = iHaltReq | haltPend_q;
    redirect = runLike & ~hazard & jumpReq;
    halted   = (state_q == HALT) & iHaltReq;
    holdAll  = stallNow | (state_q == DRAIN) | halted;
  end

  assign oHoldPC   = holdAll  & ~Reset;
  assign oHoldIFID = holdAll  & ~Reset;
  assign oBubbleEX = holdAll  & ~Reset;
  assign oRedirect = redirect & ~Reset;
  assign oSquashID = squash   & ~Reset;
  assign oHalted   = halted   & ~Reset;
  assign oStallCnt = stallCnt_q;
  assign oFlushCnt = flushCnt_q;

  always_comb begin
    pA_d       = {pA_q[1:0], (|iSelAID) & iValidID & ~holdAll & ~squash};
    pB_d       = {pB_q[1:0], (|iSelBID) & iValidID & ~holdAll & ~squash};
    state_d    = state_q;
    jmpPend_d  = 1'b0;
    haltPend_d = 1'b0;
    // A deferred jump or halt is remembered across the stall so neither is lost.
    if (runLike) begin
      if (hazard) begin
        state_d    = STALL;
        jmpPend_d  = jumpReq;
        haltPend_d = haltWant;
      end else if (jumpReq) begin
        state_d    = FLUSH;
        haltPend_d = haltWant;
      end else if (haltWant) begin
        state_d    = DRAIN;
      end else begin
        state_d    = RUN;
      end
    end else begin
      case (state_q)
        FLUSH:   state_d = haltWant ? DRAIN : RUN;
        DRAIN:   state_d = ((pA_q == 3'b000) && (pB_q == 3'b000)) ? HALT : DRAIN;
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (stallNow && !(&stallCnt_q)) stallCnt_d = stallCnt_q + CNT_W'(1);
    if (redirect && !(&flushCnt_q)) flushCnt_d = flushCnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= RUN;
      pA_q       <= 3'b000;
      pB_q       <= 3'b000;
      jmpPend_q  <= 1'b0;
      haltPend_q <= 1'b0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pA_q       <= pA_d;
      pB_q       <= pB_d;
      jmpPend_q  <= jmpPend_d;
      haltPend_q <= haltPend_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed pipeline scenarios plus randomized traffic,
// checked against a queue-based in-flight-write model of the pipeline.
module tb_hazard_unit;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic       rdA;
    logic       rdB;
    logic [1:0] selA;
    logic [1:0] selB;
    logic       jmp;
    logic       br;
    logic       haltReq;
  } stim_t;

  typedef struct packed {
    logic [5:0] flags;
    int         stallCnt;
    int         flushCnt;
  } exp_t;

  logic          Clock = 1'b0;
  logic          Reset, iValidID, iRdA, iRdB, iJmpID, iBranchID, iHaltReq;
  logic [1:0]    iSelAID, iSelBID;
  logic          oHoldPC, oHoldIFID, oBubbleEX, oRedirect, oSquashID, oHalted;
  logic [CW-1:0] oStallCnt, oFlushCnt;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  exp_t expQ[$];

  // Model: each in-flight write is a lifetime counter (cycles left in EX/ME/WB).
  int  wrA[$];
  int  wrB[$];
  bit  mFlush, mDrain, mHalt, mJmpLater, mHaltLater;
  int  mStall, mFlushN;

  hazard_unit #(.CNT_W(CW)) dut (
    .Clock(Clock), .Reset(Reset), .iValidID(iValidID), .iRdA(iRdA), .iRdB(iRdB),
    .iSelAID(iSelAID), .iSelBID(iSelBID), .iJmpID(iJmpID), .iBranchID(iBranchID),
    .iHaltReq(iHaltReq), .oHoldPC(oHoldPC), .oHoldIFID(oHoldIFID), .oBubbleEX(oBubbleEX),
    .oRedirect(oRedirect), .oSquashID(oSquashID), .oHalted(oHalted),
    .oStallCnt(oStallCnt), .oFlushCnt(oFlushCnt)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle, actual, expected);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic void ageOut(ref int q[$]);
    int keep[$];
    foreach (q[i]) if (q[i] > 1) keep.push_back(q[i] - 1);
    q = keep;
  endfunction

  // Computes this cycle's expected outputs, queues them, then advances the model.
  function automatic void modelStep(input stim_t s);
    exp_t e;
    bit   normal, haz, jump, redir, hold, haltWant, wasEmpty;
    e.stallCnt = mStall;
    e.flushCnt = mFlushN;
    if (s.rst) begin
      e.flags = 6'b0;
      expQ.push_back(e);
      wrA.delete(); wrB.delete();
      mFlush = 0; mDrain = 0; mHalt = 0; mJmpLater = 0; mHaltLater = 0;
      mStall = 0; mFlushN = 0;
      return;
    end
    normal   = !mFlush && !mDrain && !(mHalt && s.haltReq);
    haz      = normal && s.valid && ((s.rdA && wrA.size() > 0) || (s.rdB && wrB.size() > 0));
    jump     = ((s.jmp || s.br) && s.valid) || mJmpLater;
    redir    = normal && !haz && jump;
    hold     = haz || mDrain || (mHalt && s.haltReq);
    haltWant = s.haltReq || mHaltLater;
    e.flags  = {hold, hold, hold, redir, mFlush, mHalt && s.haltReq};
    expQ.push_back(e);
    wasEmpty = (wrA.size() == 0) && (wrB.size() == 0);
    ageOut(wrA);
    ageOut(wrB);
    if (s.valid && !hold && !mFlush) begin
      if (s.selA != 2'b00) wrA.push_back(3);
      if (s.selB != 2'b00) wrB.push_back(3);
    end
    if (haz)   mStall  = sat(mStall);
    if (redir) mFlushN = sat(mFlushN);
    if (normal) begin
      mHalt = 0;
      if (haz) begin
        mJmpLater = jump; mHaltLater = haltWant;
      end else if (jump) begin
        mFlush = 1; mJmpLater = 0; mHaltLater = haltWant;
      end else begin
        mDrain = haltWant; mJmpLater = 0; mHaltLater = 0;
      end
    end else if (mFlush) begin
      mFlush = 0; mDrain = haltWant; mJmpLater = 0; mHaltLater = 0;
    end else if (mDrain) begin
      if (wasEmpty) begin
        mDrain = 0; mHalt = 1;
      end
    end
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(posedge Clock);
    #1;
    cycle++;
    Reset = s.rst; iValidID = s.valid; iRdA = s.rdA; iRdB = s.rdB;
    iSelAID = s.selA; iSelBID = s.selB; iJmpID = s.jmp; iBranchID = s.br; iHaltReq = s.haltReq;
    modelStep(s);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("flags", {26'b0, oHoldPC, oHoldIFID, oBubbleEX, oRedirect, oSquashID, oHalted},
                    {26'b0, e.flags});
        checkOutput("stallCnt", 32'(oStallCnt), e.stallCnt);
        checkOutput("flushCnt", 32'(oFlushCnt), e.flushCnt);
      end
    end
  end

  initial begin : driver
    stim_t s, rst, prodA, consA;
    int    waitN;
    Reset = 1'b1; iValidID = 0; iRdA = 0; iRdB = 0; iSelAID = 0; iSelBID = 0;
    iJmpID = 0; iBranchID = 0; iHaltReq = 0;
    rst = idle(); rst.rst = 1'b1;
    prodA = idle(); prodA.valid = 1'b1; prodA.selA = 2'd2;
    consA = idle(); consA.valid = 1'b1; consA.rdA = 1'b1;

    applyStimulus(rst);
    applyStimulus(rst);
    @(negedge Clock);
    checkOutput("resetOutputs", {26'b0, oHoldPC, oHoldIFID, oBubbleEX, oRedirect, oSquashID, oHalted}, 32'd0);

    // Back-to-back producer/consumer of A: three stall cycles.
    applyStimulus(prodA);
    applyStimulus(consA);
    @(negedge Clock);
    checkOutput("stall3Bubble", 32'(oBubbleEX), 32'd1);
    applyStimulus(consA);
    applyStimulus(consA);
    applyStimulus(consA);
    @(negedge Clock);
    checkOutput("stall3Release", 32'(oBubbleEX), 32'd0);
    checkOutput("stall3Count", 32'(oStallCnt), 32'd3);
    applyStimulus(rst);

    // One independent instruction in between: two stall cycles.
    s = idle(); s.valid = 1'b1;
    applyStimulus(prodA);
    applyStimulus(s);
    repeat (3) applyStimulus(consA);
    @(negedge Clock);
    checkOutput("stall2Count", 32'(oStallCnt), 32'd2);
    applyStimulus(rst);

    // Clean jump: redirect then squash.
    s = idle(); s.valid = 1'b1; s.jmp = 1'b1;
    applyStimulus(s);
    @(negedge Clock);
    checkOutput("jumpRedirect", 32'(oRedirect), 32'd1);
    s = idle(); s.valid = 1'b1;
    applyStimulus(s);
    @(negedge Clock);
    checkOutput("jumpSquash", 32'(oSquashID), 32'd1);
    checkOutput("jumpFlushCnt", 32'(oFlushCnt), 32'd1);
    applyStimulus(rst);

    // Jump reading B while its producer sits in ME: redirect deferred two cycles.
    s = idle(); s.valid = 1'b1; s.selB = 2'd1;
    applyStimulus(s);
    s = idle(); s.valid = 1'b1;
    applyStimulus(s);
    s = idle(); s.valid = 1'b1; s.jmp = 1'b1; s.rdB = 1'b1;
    applyStimulus(s);
    @(negedge Clock);
    checkOutput("deferJmp0", 32'(oRedirect), 32'd0);
    applyStimulus(s);
    @(negedge Clock);
    checkOutput("deferJmp1", 32'(oRedirect), 32'd0);
    applyStimulus(s);
    @(negedge Clock);
    checkOutput("deferJmp2", 32'(oRedirect), 32'd1);
    applyStimulus(idle());
    @(negedge Clock);
    checkOutput("deferSquash", 32'(oSquashID), 32'd1);
    applyStimulus(rst);

    // Halt with pA=011: three drain cycles, then halted, then release.
    applyStimulus(prodA);
    applyStimulus(prodA);
    s = idle(); s.haltReq = 1'b1;
    applyStimulus(s);
    repeat (3) applyStimulus(s);
    @(negedge Clock);
    checkOutput("drainNotHalted", 32'(oHalted), 32'd0);
    checkOutput("drainHold", 32'(oHoldPC), 32'd1);
    applyStimulus(s);
    @(negedge Clock);
    checkOutput("halted", 32'(oHalted), 32'd1);
    applyStimulus(idle());
    @(negedge Clock);
    checkOutput("haltRelease", 32'(oHalted), 32'd0);
    checkOutput("haltReleaseHold", 32'(oHoldPC), 32'd0);
    applyStimulus(rst);

    // Reset mid-stall clears the scoreboard.
    applyStimulus(prodA);
    applyStimulus(consA);
    applyStimulus(rst);
    @(negedge Clock);
    checkOutput("rstStallOut", {26'b0, oHoldPC, oHoldIFID, oBubbleEX, oRedirect, oSquashID, oHalted}, 32'd0);
    applyStimulus(consA);
    @(negedge Clock);
    checkOutput("rstStallBubble", 32'(oBubbleEX), 32'd0);
    checkOutput("rstStallCnt", 32'(oStallCnt), 32'd0);

    // Randomized traffic.
    s = idle();
    for (int i = 0; i < 3000; i++) begin
      s.rst     = ($urandom_range(0, 299) == 0);
      s.valid   = ($urandom_range(0, 3) != 0);
      s.rdA     = 1'($urandom_range(0, 1));
      s.rdB     = 1'($urandom_range(0, 1));
      s.selA    = 2'($urandom_range(0, 3));
      s.selB    = 2'($urandom_range(0, 3));
      s.jmp     = ($urandom_range(0, 7) == 0);
      s.br      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 24) == 0) s.haltReq = ~s.haltReq;
      applyStimulus(s);
    end

    waitN = 0;
    while (expQ.size() > 0 && waitN < 10) begin
      @(negedge Clock);
      waitN++;
    end
    #1;
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drainQueue actual=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
